// File: rtl/pipe_ctrl_credit.sv
// Pipeline controller for the CORDIC datapath.
// A non-stalling valid shift register drives the per-stage enables. An output skid FIFO
// catches every beat that leaves the last stage. Upstream ready comes from a credit counter
// that covers beats in flight plus beats buffered, so no beat is admitted without a FIFO slot
// reserved for it. This also removes any combinational path from downstream ready to
// upstream ready.
module pipe_ctrl_credit #(
    parameter int unsigned PIPE_DEPTH = 6,
    parameter int unsigned BUF_DEPTH  = 8,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned LVL_W      = $clog2(BUF_DEPTH + 1)
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  flush_i,
    input  logic                  tvalid_data_i,
    output logic                  tready_data_i,
    output logic [PIPE_DEPTH-1:0] en_o,
    input  logic [DATA_W-1:0]     pipe_tdata_i,
    output logic                  tvalid_data_o,
    input  logic                  tready_data_o,
    output logic [DATA_W-1:0]     tdata_o,
    output logic [LVL_W-1:0]      level_o
);

    localparam int unsigned PtrW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam logic [LVL_W-1:0] LvlFull = LVL_W'(BUF_DEPTH);
    localparam logic [LVL_W-1:0] LvlOne  = LVL_W'(1);
    localparam logic [PtrW-1:0]  PtrLast = PtrW'(BUF_DEPTH - 1);
    localparam logic [PtrW-1:0]  PtrOne  = PtrW'(1);

    // valid_q[k-1] holds v[k]; v[0] is the combinational accept
    logic [PIPE_DEPTH-1:0] valid_q, valid_d;
    logic [LVL_W-1:0]      cnt_q, cnt_d;
    logic [LVL_W-1:0]      fifo_cnt_q, fifo_cnt_d;
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0]     mem_q [BUF_DEPTH];

    logic acc;
    logic pop;
    logic wr_en;

    // Modulo-BUF_DEPTH increment; BUF_DEPTH need not be a power of two.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        logic [PtrW-1:0] r;
        if (p == PtrLast) begin
            r = '0;
        end else begin
            r = p + PtrOne;
        end
        return r;
    endfunction

    // Handshakes. areset gates ready so nothing is admitted while reset is held.
    always_comb begin
        tready_data_i = !areset && (cnt_q < LvlFull) && !flush_i;
        acc           = tvalid_data_i && tready_data_i;
        tvalid_data_o = (fifo_cnt_q != '0);
        // A pop coinciding with flush is discarded along with everything else.
        pop           = tvalid_data_o && tready_data_o && !flush_i;
        wr_en         = valid_q[PIPE_DEPTH-1] && !flush_i;
        tdata_o       = mem_q[rd_ptr_q];
        level_o       = cnt_q;
    end

    // Stage enables are v[0..PIPE_DEPTH-1]; the shift register takes the same vector next.
    always_comb begin
        en_o    = PIPE_DEPTH'({valid_q, acc});
        valid_d = flush_i ? '0 : en_o;
    end

    // Credit counter: one credit per accepted beat, returned on pop.
    always_comb begin
        cnt_d = cnt_q;
        if (flush_i) begin
            cnt_d = '0;
        end else if (acc && !pop) begin
            cnt_d = cnt_q + LvlOne;
        end else if (pop && !acc) begin
            cnt_d = cnt_q - LvlOne;
        end
    end

    // FIFO pointers and occupancy.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        if (flush_i) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            fifo_cnt_d = '0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (wr_en && !pop) begin
                fifo_cnt_d = fifo_cnt_q + LvlOne;
            end else if (pop && !wr_en) begin
                fifo_cnt_d = fifo_cnt_q - LvlOne;
            end
        end
    end

    // Control state registers.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            valid_q    <= '0;
            cnt_q      <= '0;
            fifo_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            valid_q    <= valid_d;
            cnt_q      <= cnt_d;
            fifo_cnt_q <= fifo_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // FIFO storage. The credit scheme guarantees a free slot whenever the last stage is valid.
    always_ff @(posedge aclk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= pipe_tdata_i;
        end
    end

endmodule
